// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session arbiter: menu codes, core modes
// and the session FSM state encoding.
package atm_pkg;

   localparam logic [2:0] WAITING               = 3'b000;
   localparam logic [2:0] GET_PIN               = 3'b001;
   localparam logic [2:0] MENU                  = 3'b010;
   localparam logic [2:0] BALANCE               = 3'b011;
   localparam logic [2:0] WITHDRAW              = 3'b100;
   localparam logic [2:0] WITHDRAW_SHOW_BALANCE = 3'b101;
   localparam logic [2:0] TRANSFER              = 3'b110;
   localparam logic [2:0] DEPOSIT               = 3'b111;

   localparam logic FIND         = 1'b0;
   localparam logic AUTHENTICATE = 1'b1;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_AUTH,
      S_WAIT_AUTH,
      S_OP,
      S_WAIT_OP,
      S_RESP
   } state_t;

   // Only BALANCE through DEPOSIT are operations the core can execute.
   function automatic logic is_op_menu(input logic [2:0] m);
      return (m >= BALANCE);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible requester at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [N-1:0]  mask_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          valid_o
);

   logic [N-1:0] elig;

   assign elig = req_i & mask_i;

   always_comb begin
      int c;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      c       = 0;
      for (int i = 0; i < N; i++) begin
         c = (int'(ptr_i) + i) % N;
         if (!valid_o && elig[c]) begin
            valid_o  = 1'b1;
            idx_o    = PW'(c);
            gnt_o[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/atm_session_arbiter.sv
// Shares one ATM core between N_TERM terminals: round-robin session grant,
// PIN authentication, one operation, response strobe, and PIN-failure lockout.
module atm_session_arbiter
   import atm_pkg::*;
#(
   parameter int N_TERM       = 4,
   parameter int TIMEOUT      = 15,
   parameter int MAX_PIN_FAIL = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_TERM-1:0]    req,
   input  logic [12*N_TERM-1:0] acc_number,
   input  logic [4*N_TERM-1:0]  pin,
   input  logic [12*N_TERM-1:0] dest_acc,
   input  logic [3*N_TERM-1:0]  menu_option,
   input  logic [11*N_TERM-1:0] amount,
   output logic [N_TERM-1:0]    gnt,
   output logic [N_TERM-1:0]    resp_valid,
   output logic                 resp_error,
   output logic [10:0]          resp_balance,
   output logic [N_TERM-1:0]    locked,
   output logic                 core_start,
   output logic                 core_mode,
   output logic [2:0]           core_menu,
   output logic [11:0]          core_acc,
   output logic [3:0]           core_pin,
   output logic [11:0]          core_dest,
   output logic [10:0]          core_amount,
   input  logic                 core_done,
   input  logic                 core_error,
   input  logic [10:0]          core_balance,
   output state_t               dbg_state
);

   localparam int PW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int FW = $clog2(MAX_PIN_FAIL + 1);

   state_t                     state_q, state_d;
   logic [PW-1:0]              ptr_q, ptr_d;
   logic [PW-1:0]              idx_q, idx_d;
   logic [N_TERM-1:0]          gnt_q, gnt_d;
   logic [11:0]                acc_q, acc_d;
   logic [3:0]                 pin_q, pin_d;
   logic [11:0]                dest_q, dest_d;
   logic [2:0]                 menu_q, menu_d;
   logic [10:0]                amount_q, amount_d;
   logic [N_TERM-1:0][FW-1:0]  fail_q, fail_d;
   logic [N_TERM-1:0]          locked_q, locked_d;
   logic [CW-1:0]              wcnt_q, wcnt_d;
   logic                       err_q, err_d;
   logic [10:0]                bal_q, bal_d;

   logic [N_TERM-1:0]          arb_gnt;
   logic [PW-1:0]              arb_idx;
   logic                       arb_valid;

   rr_arbiter #(.N(N_TERM), .PW(PW)) u_arb (
      .req_i   (req),
      .mask_i  (~locked_q),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         gnt_q    <= '0;
         acc_q    <= '0;
         pin_q    <= '0;
         dest_q   <= '0;
         menu_q   <= '0;
         amount_q <= '0;
         fail_q   <= '0;
         locked_q <= '0;
         wcnt_q   <= '0;
         err_q    <= 1'b0;
         bal_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         gnt_q    <= gnt_d;
         acc_q    <= acc_d;
         pin_q    <= pin_d;
         dest_q   <= dest_d;
         menu_q   <= menu_d;
         amount_q <= amount_d;
         fail_q   <= fail_d;
         locked_q <= locked_d;
         wcnt_q   <= wcnt_d;
         err_q    <= err_d;
         bal_q    <= bal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      gnt_d      = gnt_q;
      acc_d      = acc_q;
      pin_d      = pin_q;
      dest_d     = dest_q;
      menu_d     = menu_q;
      amount_d   = amount_q;
      fail_d     = fail_q;
      locked_d   = locked_q;
      wcnt_d     = wcnt_q;
      err_d      = err_q;
      bal_d      = bal_q;
      core_start = FALSE;
      core_mode  = FIND;
      core_menu  = menu_q;
      case (state_q)
         S_IDLE: begin
            if (arb_valid) begin
               idx_d   = arb_idx;
               gnt_d   = arb_gnt;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            acc_d    = acc_number[int'(idx_q)*12 +: 12];
            pin_d    = pin[int'(idx_q)*4 +: 4];
            dest_d   = dest_acc[int'(idx_q)*12 +: 12];
            menu_d   = menu_option[int'(idx_q)*3 +: 3];
            amount_d = amount[int'(idx_q)*11 +: 11];
            err_d    = 1'b0;
            bal_d    = '0;
            state_d  = S_AUTH;
         end
         S_AUTH: begin
            core_start = TRUE;
            core_mode  = AUTHENTICATE;
            core_menu  = MENU;
            wcnt_d     = '0;
            state_d    = S_WAIT_AUTH;
         end
         S_WAIT_AUTH: begin
            if (core_done) begin
               if (core_error) begin
                  err_d   = 1'b1;
                  bal_d   = '0;
                  state_d = S_RESP;
                  // Count saturates at the lock threshold; only rst unlocks.
                  if (int'(fail_q[idx_q]) + 1 >= MAX_PIN_FAIL) begin
                     fail_d[idx_q]   = FW'(MAX_PIN_FAIL);
                     locked_d[idx_q] = 1'b1;
                  end else begin
                     fail_d[idx_q] = fail_q[idx_q] + 1'b1;
                  end
               end else begin
                  fail_d[idx_q] = '0;
                  state_d       = S_OP;
               end
            end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               bal_d   = '0;
               state_d = S_RESP;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_OP: begin
            if (is_op_menu(menu_q)) begin
               core_start = TRUE;
               wcnt_d     = '0;
               state_d    = S_WAIT_OP;
            end else begin
               err_d   = 1'b1;
               bal_d   = '0;
               state_d = S_RESP;
            end
         end
         S_WAIT_OP: begin
            if (core_done) begin
               err_d   = core_error;
               bal_d   = core_balance;
               state_d = S_RESP;
            end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               bal_d   = '0;
               state_d = S_RESP;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_RESP: begin
            gnt_d   = '0;
            ptr_d   = (int'(idx_q) == N_TERM - 1) ? '0 : idx_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign gnt          = gnt_q;
   assign resp_valid   = (state_q == S_RESP) ? gnt_q : '0;
   assign resp_error   = (state_q == S_RESP) && err_q;
   assign resp_balance = (state_q == S_RESP) ? bal_q : '0;
   assign locked       = locked_q;
   assign core_acc     = acc_q;
   assign core_pin     = pin_q;
   assign core_dest    = dest_q;
   assign core_amount  = amount_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_atm_session_arbiter.sv
// Directed bench for atm_session_arbiter: a behavioural core model answers
// core_start, and a monitor scores every resp_valid against an expected queue.
module tb_atm_session_arbiter;
   import atm_pkg::*;

   localparam int N  = 4;
   localparam int TO = 15;
   localparam int W  = 14;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [12*N-1:0] acc_number;
   logic [4*N-1:0]  pin;
   logic [12*N-1:0] dest_acc;
   logic [3*N-1:0]  menu_option;
   logic [11*N-1:0] amount;
   logic [N-1:0]    gnt;
   logic [N-1:0]    resp_valid;
   logic            resp_error;
   logic [10:0]     resp_balance;
   logic [N-1:0]    locked;
   logic            core_start;
   logic            core_mode;
   logic [2:0]      core_menu;
   logic [11:0]     core_acc;
   logic [3:0]      core_pin;
   logic [11:0]     core_dest;
   logic [10:0]     core_amount;
   logic            core_done;
   logic            core_error;
   logic [10:0]     core_balance;
   state_t          dbg_state;

   int              check_cnt = 0;
   int              err_cnt   = 0;
   int              start_cnt = 0;
   logic [W-1:0]    exp_q[$];

   logic [11:0]     cfg_acc[N];
   logic [3:0]      cfg_pin[N];
   logic [2:0]      cfg_menu[N];
   logic [10:0]     cfg_bal[N];
   logic            cfg_auth_err[N];
   logic            cfg_op_silent[N];
   logic            phase;
   logic            prev_start;

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", check_cnt);
      $fatal(1, "watchdog");
   end

   atm_session_arbiter #(.N_TERM(N), .TIMEOUT(TO), .MAX_PIN_FAIL(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .acc_number   (acc_number),
      .pin          (pin),
      .dest_acc     (dest_acc),
      .menu_option  (menu_option),
      .amount       (amount),
      .gnt          (gnt),
      .resp_valid   (resp_valid),
      .resp_error   (resp_error),
      .resp_balance (resp_balance),
      .locked       (locked),
      .core_start   (core_start),
      .core_mode    (core_mode),
      .core_menu    (core_menu),
      .core_acc     (core_acc),
      .core_pin     (core_pin),
      .core_dest    (core_dest),
      .core_amount  (core_amount),
      .core_done    (core_done),
      .core_error   (core_error),
      .core_balance (core_balance),
      .dbg_state    (dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   // driver tasks
   task automatic set_term(input int t, input logic [11:0] a, input logic [3:0] p,
                           input logic [2:0] m, input logic [10:0] b,
                           input logic ae, input logic os);
      cfg_acc[t]       = a;
      cfg_pin[t]       = p;
      cfg_menu[t]      = m;
      cfg_bal[t]       = b;
      cfg_auth_err[t]  = ae;
      cfg_op_silent[t] = os;
      acc_number[t*12 +: 12] = a;
      pin[t*4 +: 4]          = p;
      menu_option[t*3 +: 3]  = m;
      dest_acc[t*12 +: 12]   = 12'(100 + t);
      amount[t*11 +: 11]     = 11'(50 * t + 10);
   endtask

   task automatic expect_resp(input int t, input logic e, input logic [10:0] b);
      exp_q.push_back({2'(t), e, b});
   endtask

   task automatic wait_gnt(input int t);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt[t] && n < 50);
      chk("gnt_seen", gnt[t], 1);
   endtask

   task automatic wait_resp(input int t);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid[t] && n < 100);
      chk("resp_seen", resp_valid[t], 1);
   endtask

   task automatic wait_state(input state_t s);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (dbg_state != s && n < 50);
      chk("state_reached", dbg_state == s, 1);
   endtask

   task automatic session(input int t, input logic e, input logic [10:0] b);
      expect_resp(t, e, b);
      req[t] = 1'b1;
      wait_gnt(t);
      req[t] = 1'b0;
      wait_resp(t);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_error"}, resp_error, 0);
      chk({tag, "_resp_balance"}, resp_balance, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_core_mode"}, core_mode, 0);
      chk({tag, "_core_acc"}, core_acc, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_state"}, dbg_state == S_IDLE, 1);
   endtask

   // core model: answers each core_start one cycle later unless told to stay silent
   initial begin : core_model
      int t;
      core_done    = 1'b0;
      core_error   = 1'b0;
      core_balance = '0;
      phase        = 1'b0;
      @(negedge clk);
      forever begin
         if (rst) begin
            phase = 1'b0;
            @(negedge clk);
         end else if (core_start) begin
            t = oh_idx(gnt);
            chk("core_mode", core_mode, phase ? FIND : AUTHENTICATE);
            chk("core_menu", core_menu, phase ? cfg_menu[t] : MENU);
            if (!phase) begin
               chk("core_acc", core_acc, cfg_acc[t]);
               chk("core_pin", core_pin, cfg_pin[t]);
            end
            if (phase && cfg_op_silent[t]) begin
               @(negedge clk);
            end else begin
               @(negedge clk);
               core_done    = 1'b1;
               core_error   = phase ? 1'b0 : cfg_auth_err[t];
               core_balance = phase ? cfg_bal[t] : 11'd0;
               @(negedge clk);
               core_done    = 1'b0;
               core_error   = 1'b0;
               core_balance = '0;
               if (!phase && !cfg_auth_err[t]) phase = 1'b1;
            end
         end else begin
            if (|resp_valid) phase = 1'b0;
            @(negedge clk);
         end
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      if (rst) begin
         prev_start <= 1'b0;
      end else begin
         if (core_start) begin
            chk("start_gap", prev_start, 0);
            start_cnt <= start_cnt + 1;
         end
         prev_start <= core_start;
         if (|gnt) chk("gnt_onehot", $countones(gnt), 1);
         if (|resp_valid) begin
            chk("resp_eq_gnt", resp_valid, gnt);
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               got = {2'(oh_idx(resp_valid)), resp_error, resp_balance};
               chk("scoreboard", got, exp);
            end
         end
      end
   end

   // main stimulus
   initial begin
      int n;
      int cnt;
      int hits;
      int s0;
      rst = 1'b1;
      req = '0;
      acc_number = '0;
      pin = '0;
      dest_acc = '0;
      menu_option = '0;
      amount = '0;
      for (int t = 0; t < N; t++) set_term(t, 12'(t), 4'(t), BALANCE, 11'(t), 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // basic balance enquiry on terminal 0
      set_term(0, 12'd2178, 4'b0100, 3'b011, 11'd500, 1'b0, 1'b0);
      session(0, 1'b0, 11'd500);
      chk("latched_acc", core_acc, 2178);
      chk("latched_pin", core_pin, 4'b0100);

      // reset brings ptr back to 0
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset2");
      rst = 1'b0;
      @(negedge clk);

      // three terminals requesting continuously: 0,1,2,0
      set_term(1, 12'd1001, 4'd7, 3'b100, 11'd123, 1'b0, 1'b0);
      set_term(2, 12'd2002, 4'd9, 3'b101, 11'd77, 1'b0, 1'b0);
      expect_resp(0, 1'b0, 11'd500);
      expect_resp(1, 1'b0, 11'd123);
      expect_resp(2, 1'b0, 11'd77);
      expect_resp(0, 1'b0, 11'd500);
      req[2:0] = 3'b111;
      n = 0;
      cnt = 0;
      while (cnt < 4 && n < 400) begin
         @(negedge clk);
         n++;
         if (|resp_valid) cnt++;
      end
      req = '0;
      chk("rr_sessions", cnt, 4);
      repeat (2) @(negedge clk);

      // terminal 1 fails auth three times and locks
      set_term(1, 12'd1001, 4'd7, 3'b100, 11'd123, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         session(1, 1'b1, 11'd0);
         chk("locked1", locked[1], (k == 2) ? 1 : 0);
      end
      set_term(3, 12'd3003, 4'd3, 3'b110, 11'd999, 1'b0, 1'b0);
      req[1] = 1'b1;
      session(3, 1'b0, 11'd999);
      hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (gnt[1]) hits++;
      end
      req[1] = 1'b0;
      chk("locked_no_gnt", hits, 0);

      // invalid operation code after good auth
      set_term(2, 12'd2002, 4'd9, 3'b001, 11'd77, 1'b0, 1'b0);
      s0 = start_cnt;
      session(2, 1'b1, 11'd0);
      chk("op_starts", start_cnt - s0, 1);

      // core never completes the operation
      set_term(3, 12'd3003, 4'd3, 3'b111, 11'd0, 1'b0, 1'b1);
      expect_resp(3, 1'b1, 11'd0);
      req[3] = 1'b1;
      wait_gnt(3);
      req[3] = 1'b0;
      wait_state(S_WAIT_OP);
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!resp_valid[3] && cnt < 100);
      chk("timeout_cycles", cnt, TO);
      repeat (2) @(negedge clk);

      // reset while waiting on the core drops the session
      set_term(0, 12'd2178, 4'b0100, 3'b011, 11'd500, 1'b0, 1'b1);
      req[0] = 1'b1;
      wait_gnt(0);
      req[0] = 1'b0;
      wait_state(S_WAIT_OP);
      #1 rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);

      // terminal 1 unlocked after reset
      set_term(1, 12'd1001, 4'd7, 3'b100, 11'd123, 1'b0, 1'b0);
      session(1, 1'b0, 11'd123);

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule
